// File: rtl/data_memory_unit.sv
// data_memory_unit
//   Byte-addressed, big-endian data memory for the MEM stage. Handles byte,
//   halfword and word accesses in one edge and doublewords in two edges
//   (IDLE -> DW2). Load data is registered for the MEM/WB register.
//
// Ports
//   CLK, CLR          clock, synchronous active-high reset
//   Enable_In, rw_In  access request, 0 = load / 1 = store
//   Size_In           00 byte, 01 halfword, 10 word, 11 doubleword
//   Address_In        byte address
//   Data_In/Data2_In  store data (Data2_In = second doubleword word)
//   Data_Out/Data2_Out registered load data (zero-extended for byte/half)
//   Done_Out          pulse: access completed at the preceding edge
//   Stall_Out         combinational: hold pipeline inputs this cycle
//   Fault_Out         pulse: misaligned request rejected
module data_memory_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Enable_In,
  input  logic              rw_In,
  input  logic [1:0]        Size_In,
  input  logic [ADDR_W-1:0] Address_In,
  input  logic [31:0]       Data_In,
  input  logic [31:0]       Data2_In,
  output logic [31:0]       Data_Out,
  output logic [31:0]       Data2_Out,
  output logic              Done_Out,
  output logic              Stall_Out,
  output logic              Fault_Out
);

  typedef enum logic {IDLE, DW2} state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  state_t            state, next_state;
  logic [ADDR_W-1:0] dw_addr;

  logic              aligned;
  logic              acc_en;
  logic              wr_en;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_size;
  logic [31:0]       acc_data;
  logic [ADDR_W-1:0] b0, b1, b2, b3;
  logic [31:0]       rd_word;
  logic [31:0]       rd_ext;

  // Alignment of the incoming request (only meaningful in IDLE)
  always_comb begin
    aligned = 1'b1;
    case (Size_In)
      SZ_H:       aligned = ~Address_In[0];
      SZ_W, SZ_D: aligned = (Address_In[1:0] == 2'b00);
      default:    aligned = 1'b1;
    endcase
  end

  // Access selection: IDLE uses the request directly; DW2 accesses the
  // second word of the latched doubleword with the current rw_In/Data2_In.
  always_comb begin
    acc_en   = 1'b0;
    acc_addr = Address_In;
    acc_size = Size_In;
    acc_data = Data_In;
    if (state == IDLE) begin
      acc_en = Enable_In && aligned;
    end else begin
      acc_en   = 1'b1;
      acc_addr = dw_addr + ADDR_W'(4);   // wraps modulo the array depth
      acc_size = SZ_W;
      acc_data = Data2_In;
    end
  end

  // CLR blocks the store even when a request is present in the same cycle
  assign wr_en = acc_en && rw_In && !CLR;

  assign Stall_Out = (state == IDLE) && Enable_In && aligned && (Size_In == SZ_D);

  assign b0 = acc_addr;
  assign b1 = acc_addr + ADDR_W'(1);
  assign b2 = acc_addr + ADDR_W'(2);
  assign b3 = acc_addr + ADDR_W'(3);

  assign rd_word = {mem[b0], mem[b1], mem[b2], mem[b3]};

  always_comb begin
    rd_ext = rd_word;
    case (acc_size)
      SZ_B:    rd_ext = {24'b0, mem[b0]};
      SZ_H:    rd_ext = {16'b0, mem[b0], mem[b1]};
      default: rd_ext = rd_word;
    endcase
  end

  // FSM next state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Enable_In && aligned && (Size_In == SZ_D)) next_state = DW2;
      DW2:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) state <= IDLE;
    else     state <= next_state;
  end

  // Storage array, never reset
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      case (acc_size)
        SZ_B: mem[b0] <= acc_data[7:0];
        SZ_H: begin
          mem[b0] <= acc_data[15:8];
          mem[b1] <= acc_data[7:0];
        end
        default: begin
          mem[b0] <= acc_data[31:24];
          mem[b1] <= acc_data[23:16];
          mem[b2] <= acc_data[15:8];
          mem[b3] <= acc_data[7:0];
        end
      endcase
    end
  end

  // Registered outputs and doubleword address latch
  always_ff @(posedge CLK) begin
    if (CLR) begin
      Data_Out  <= '0;
      Data2_Out <= '0;
      Done_Out  <= 1'b0;
      Fault_Out <= 1'b0;
      dw_addr   <= '0;
    end else begin
      Done_Out  <= 1'b0;
      Fault_Out <= 1'b0;
      if (state == IDLE) begin
        if (Enable_In) begin
          if (!aligned) begin
            Fault_Out <= 1'b1;
          end else if (Size_In == SZ_D) begin
            if (!rw_In) Data_Out <= rd_word;
            dw_addr <= Address_In;
          end else begin
            if (!rw_In) Data_Out <= rd_ext;
            Done_Out <= 1'b1;
          end
        end
      end else begin
        if (!rw_In) Data2_Out <= rd_word;
        Done_Out <= 1'b1;
      end
    end
  end

endmodule
